// File: rtl/btn_input_pkg.sv
// btn_input_pkg: shared definitions for the push-button front end.
//   - btn_state_e : per-channel debounce state encoding (2 bits)
//   - CLK_HZ and the default 10 ms debounce / 1 s long-press cycle counts
// Optional feature macro used by the design files: BTN_INPUT_LONG_PRESS_EN.
package btn_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ                = 32'd200_000_000;
  // 10 ms of stable input before a new level is accepted
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = CLK_HZ / 32'd100;
  // 1 s of debounced-pressed level before a long-press pulse
  localparam int unsigned DEF_LONG_PRESS_CYCLES = CLK_HZ;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one push-button channel.
//   Two-flop synchroniser, four-state debounce FSM, registered press/release
//   pulses and (with BTN_INPUT_LONG_PRESS_EN defined) a saturating hold
//   counter that emits a single long-press pulse per press.
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   i_raw      asynchronous raw pin, 1 = pressed
//   o_level    debounced level
//   o_press    1-cycle pulse on debounced 0->1
//   o_release  1-cycle pulse on debounced 1->0
//   o_long     1-cycle pulse when held LONG_PRESS_CYCLES (0 when macro undefined)
module btn_debounce_ch
  import btn_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  // With a one-cycle debounce the WAIT states would never match CNT_LAST
  // after being entered with cnt=1, so IDLE/PRESSED jump straight across.
  localparam bit                 DB_SINGLE = (DEBOUNCE_CYCLES == 32'd1);

  logic             r_sync1;
  logic             r_sync;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Synchroniser chain, FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1   <= 1'b0;
      r_sync    <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= CNT_ZERO;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync    <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Debounce next-state, counter and pulse decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sync) begin
          if (DB_SINGLE) begin
            w_state_nxt = ST_PRESSED;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_state_nxt = ST_WAIT_PRESS;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_cnt_nxt = CNT_ZERO;
        end
      end
      ST_WAIT_PRESS: begin
        if (!r_sync) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!r_sync) begin
          if (DB_SINGLE) begin
            w_state_nxt   = ST_IDLE;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
            w_cnt_nxt     = CNT_ZERO;
          end else begin
            w_state_nxt = ST_WAIT_RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_cnt_nxt = CNT_ZERO;
        end
      end
      ST_WAIT_RELEASE: begin
        if (r_sync) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_cnt_nxt     = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BTN_INPUT_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_PRESS_CYCLES + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 32'd2);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_long_nxt;

  // Hold counter: runs while the debounced level is 1 (WAIT_RELEASE included)
  // and parks at HOLD_LAST so only one long pulse is produced per press.
  always_comb begin
    w_hold_nxt = r_hold;
    w_long_nxt = 1'b0;
    if (!r_level) begin
      // Covers the entry into PRESSED from WAIT_PRESS as well.
      w_hold_nxt = HOLD_ZERO;
    end else if (r_hold != HOLD_LAST) begin
      w_hold_nxt = r_hold + HOLD_ONE;
      w_long_nxt = (r_hold == HOLD_PRE);
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold <= HOLD_ZERO;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_long <= w_long_nxt;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_input.sv
// btn_input: board push-button front end, N_BTN independent channels.
//   Each bit of btn_raw is handled by its own btn_debounce_ch; this level
//   only fans bits in and out. Long-press detection is built only when
//   BTN_INPUT_LONG_PRESS_EN is defined; otherwise btn_long is constant 0.
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   btn_raw      raw asynchronous pins, 1 = pressed
//   btn_level    debounced level per channel
//   btn_press    1-cycle pulse on debounced 0->1
//   btn_release  1-cycle pulse on debounced 1->0
//   btn_long     1-cycle pulse when a press is held LONG_PRESS_CYCLES
module btn_input
  import btn_input_pkg::*;
#(
  parameter int unsigned N_BTN             = 32'd3,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_long   (btn_long[g])
    );
  end

endmodule

// File: tb/tb_btn_input.sv
// tb_btn_input: scoreboard bench for btn_input (N_BTN=3, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20). Stimulus pushes expected output events and level
// snapshots, tagged with the clock-edge number at which they must appear;
// the monitor pops and compares at every falling edge.
module tb_btn_input;

`ifdef BTN_INPUT_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] btn_raw;
  logic [2:0] btn_level, btn_press, btn_release, btn_long;

  typedef struct {
    int         cyc;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] lng;
  } exp_t;

  exp_t evq[$];
  exp_t snq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;
  int   t;

  btn_input #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [2:0] l, input logic [2:0] p,
                         input logic [2:0] r, input logic [2:0] g);
    exp_t e;
    e.cyc = c; e.lvl = l; e.prs = p; e.rel = r; e.lng = g;
    evq.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [2:0] l);
    exp_t e;
    e.cyc = c; e.lvl = l; e.prs = 3'b000; e.rel = 3'b000; e.lng = 3'b000;
    snq.push_back(e);
  endtask

  task automatic cmp(input string tag, input exp_t e);
    total++;
    if ({btn_level, btn_press, btn_release, btn_long} !== {e.lvl, e.prs, e.rel, e.lng}) begin
      bad++;
      $display("FAIL %s cyc=%0d got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
               tag, cyc, btn_level, btn_press, btn_release, btn_long,
               e.lvl, e.prs, e.rel, e.lng);
    end
  endtask

  // Monitor: compares snapshots and output events against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      total++;
      if (evq.size() != 0 || snq.size() != 0) begin
        bad++;
        $display("FAIL leftover got events=%0d snaps=%0d want 0 0", evq.size(), snq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else begin
      while (snq.size() > 0 && snq[0].cyc <= cyc) begin
        mon_e = snq.pop_front();
        cmp("snapshot", mon_e);
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        mon_e = evq.pop_front();
        total++;
        bad++;
        $display("FAIL missing_event got none want prs=%b rel=%b lng=%b at cyc=%0d",
                 mon_e.prs, mon_e.rel, mon_e.lng, mon_e.cyc);
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        mon_e = evq.pop_front();
        cmp("event", mon_e);
      end else if (|{btn_press, btn_release, btn_long}) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got prs=%b rel=%b lng=%b want 000",
                 cyc, btn_press, btn_release, btn_long);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus. A raw change driven at the falling edge after edge c
  // is first sampled at edge c+1; output appears after edge c+2+4 = c+6.
  initial begin
    resetn  = 1'b0;
    btn_raw = 3'b111;
    @(negedge clk);
    push_snap(cyc + 1, 3'b000);
    push_snap(cyc + 2, 3'b000);
    tick(3);

    // Reset released with all buttons held.
    resetn = 1'b1;
    t = cyc;
    push_ev(t + 6, 3'b111, 3'b111, 3'b000, 3'b000);
    if (LONG_EN) push_ev(t + 25, 3'b111, 3'b000, 3'b000, 3'b111);
    tick(30);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b111, 3'b000);
    tick(12);

    // Clean press on bit0, release 8 cycles later, no long pulse.
    t = cyc;
    btn_raw = 3'b001;
    push_ev(t + 6, 3'b001, 3'b001, 3'b000, 3'b000);
    tick(8);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b001, 3'b000);
    tick(12);

    // Bit1 glitch: high for 3 cycles, one short of acceptance.
    btn_raw = 3'b010;
    tick(3);
    btn_raw = 3'b000;
    tick(8);
    push_snap(cyc + 1, 3'b000);
    tick(2);

    // Bit1 press with a 2-cycle low glitch; long fires on schedule.
    t = cyc;
    btn_raw = 3'b010;
    push_ev(t + 6, 3'b010, 3'b010, 3'b000, 3'b000);
    if (LONG_EN) push_ev(t + 25, 3'b010, 3'b000, 3'b000, 3'b010);
    tick(10);
    btn_raw = 3'b000;
    push_snap(cyc + 6, 3'b010);
    tick(2);
    btn_raw = 3'b010;
    tick(18);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b010, 3'b000);
    tick(12);

    // Bit2 held 40 cycles: exactly one long pulse, then re-press.
    t = cyc;
    btn_raw = 3'b100;
    push_ev(t + 6, 3'b100, 3'b100, 3'b000, 3'b000);
    if (LONG_EN) push_ev(t + 25, 3'b100, 3'b000, 3'b000, 3'b100);
    tick(40);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b100, 3'b000);
    tick(12);
    t = cyc;
    btn_raw = 3'b100;
    push_ev(t + 6, 3'b100, 3'b100, 3'b000, 3'b000);
    if (LONG_EN) push_ev(t + 25, 3'b100, 3'b000, 3'b000, 3'b100);
    tick(30);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b100, 3'b000);
    tick(12);

    // Bits 0 and 1 together.
    t = cyc;
    btn_raw = 3'b011;
    push_ev(t + 6, 3'b011, 3'b011, 3'b000, 3'b000);
    tick(10);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b011, 3'b000);
    tick(12);

    // Reset while bit0 is in WAIT_PRESS: no pulse, progress discarded.
    btn_raw = 3'b001;
    tick(3);
    resetn  = 1'b0;
    btn_raw = 3'b000;
    push_snap(cyc + 1, 3'b000);
    tick(2);
    resetn = 1'b1;
    push_snap(cyc + 3, 3'b000);
    tick(8);

    // Channel behaves normally from IDLE afterwards.
    t = cyc;
    btn_raw = 3'b001;
    push_ev(t + 6, 3'b001, 3'b001, 3'b000, 3'b000);
    tick(8);
    btn_raw = 3'b000;
    push_ev(cyc + 6, 3'b000, 3'b000, 3'b001, 3'b000);
    tick(12);

    done = 1'b1;
  end

endmodule
